// File: rtl/seg_display_receiver.sv
// Seven-segment display receiver: samples the multiplexed seg/AN bus, waits for a
// stable window, decodes the segment pattern back to hex and tracks refresh frames.
module seg_display_receiver #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic [3:0] AN,
    output logic [3:0] bin0,
    output logic [3:0] bin1,
    output logic [3:0] bin2,
    output logic [3:0] bin3,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       decode_err
);

    localparam logic [7:0]  SettleW    = 8'(SETTLE);
    localparam logic [23:0] TimeoutW   = 24'(TIMEOUT);
    localparam logic [23:0] TimeoutM1W = 24'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StAccept, StHold} state_t;

    // Returns {legal, value} for an active-low gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        unique case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1a;
            7'h03:   r = 5'h1b;
            7'h46:   r = 5'h1c;
            7'h21:   r = 5'h1d;
            7'h06:   r = 5'h1e;
            7'h0e:   r = 5'h1f;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [6:0]       seg_meta, seg_sync;
    logic [3:0]       an_meta, an_sync;
    state_t           state_q, state_d;
    logic [10:0]      pat_q, pat_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [23:0]      idle_q, idle_d;
    logic [3:0][3:0]  bin_q, bin_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       seen_q, seen_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic             accept;
    logic [10:0]      cur;
    logic             an_legal;
    logic [4:0]       dec;
    logic [1:0]       idx;

    assign cur      = {seg_sync, an_sync};
    assign an_legal = $onehot(~an_sync);
    assign dec      = decode(pat_q[10:4]);

    // Digit slot selected by the latched one-hot-low anode pattern.
    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!pat_q[i]) idx = 2'(i);
        end
    end

    // Capture FSM: settle window, single accept, hold until the bus changes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (an_legal) begin
                    state_d = StSettle;
                    cnt_d   = 8'd1;
                    pat_d   = cur;
                end
            end
            StSettle: begin
                if (cnt_q == SettleW) begin
                    state_d = StAccept;
                    accept  = 1'b1;
                end else if (cur == pat_q) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (an_legal) begin
                    pat_d = cur;
                    cnt_d = 8'd1;
                end else begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end
            end
            StAccept: begin
                state_d = StHold;
            end
            StHold: begin
                if (cur != pat_q) begin
                    if (an_legal) begin
                        state_d = StSettle;
                        cnt_d   = 8'd1;
                        pat_d   = cur;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Digit capture, frame tracking and inactivity timeout; accept beats timeout.
    always_comb begin
        bin_d   = bin_q;
        valid_d = valid_q;
        seen_d  = seen_q;
        frame_d = 1'b0;
        err_d   = 1'b0;
        idle_d  = idle_q;
        if (accept) begin
            idle_d = 24'd0;
            if (dec[4]) begin
                bin_d[idx]   = dec[3:0];
                valid_d[idx] = 1'b1;
                seen_d[idx]  = 1'b1;
                if (seen_d == 4'hf) begin
                    frame_d = 1'b1;
                    seen_d  = 4'h0;
                end
            end else begin
                err_d        = 1'b1;
                valid_d[idx] = 1'b0;
            end
        end else begin
            if (idle_q == TimeoutM1W) begin
                valid_d = 4'h0;
                seen_d  = 4'h0;
            end
            if (idle_q != TimeoutW) idle_d = idle_q + 24'd1;
        end
    end

    // Input synchronizer; resets to an idle (blank) bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_meta <= '1;
            seg_sync <= '1;
            an_meta  <= '1;
            an_sync  <= '1;
        end else begin
            seg_meta <= seg;
            seg_sync <= seg_meta;
            an_meta  <= AN;
            an_sync  <= an_meta;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= '1;
            cnt_q   <= '0;
            idle_q  <= '0;
            bin_q   <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign bin0        = bin_q[0];
    assign bin1        = bin_q[1];
    assign bin2        = bin_q[2];
    assign bin3        = bin_q[3];
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign decode_err  = err_q;

endmodule

// File: tb/tb_seg_display_receiver.sv
// Bench for seg_display_receiver: a stimulus list of held bus values is built up
// front, a run-length reference model predicts every visible output change with
// its cycle, and a monitor compares DUT output changes against that queue.
module tb_seg_display_receiver;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] bin0, bin1, bin2, bin3, digit_valid;
    logic       frame_done, decode_err;

    seg_display_receiver #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .AN          (an),
        .bin0        (bin0),
        .bin1        (bin1),
        .bin2        (bin2),
        .bin3        (bin3),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .decode_err  (decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [21:0] snap;
    } exp_t;

    logic [6:0] pat_tab [16];
    logic [6:0] slot_seg [$];
    logic [3:0] slot_an [$];
    bit         slot_rst [$];
    exp_t       exp_q [$];
    logic [6:0] last_seg;
    logic [3:0] last_an;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic add_seg(input logic [6:0] s, input logic [3:0] a, input int len,
                           input bit r);
        for (int i = 0; i < len; i++) begin
            slot_seg.push_back(s);
            slot_an.push_back(a);
            slot_rst.push_back(r);
        end
        last_seg = s;
        last_an  = a;
    endtask

    function automatic bit an_ok(input logic [3:0] a);
        return $countones(~a) == 1;
    endfunction

    function automatic int seg_val(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (pat_tab[i] == s) return i;
        return -1;
    endfunction

    // An edge e resets the DUT when rst was driven in slot e-1 (edge 0 is under reset).
    function automatic bit rst_edge(input int e);
        if (e == 0) return 1'b1;
        return slot_rst[e - 1];
    endfunction

    // Reference model. The capture logic sees slot e-3 at edge e. Every maximal run of
    // identical samples with a legal anode that lasts SETTLE samples is accepted once,
    // SETTLE edges after the run started.
    task automatic run_model();
        logic [3:0]  m_bin [4];
        logic [3:0]  m_valid, m_seen;
        int          idle, run_start, v_digit, sel;
        bit          run_ok, frame, err, acc;
        logic [10:0] run_val, v;
        logic [21:0] snap, prev;
        prev = '0;
        run_ok = 1'b0; run_start = 0; run_val = '1; idle = 0;
        m_valid = '0; m_seen = '0;
        for (int k = 0; k < 4; k++) m_bin[k] = '0;
        for (int e = 0; e < slot_seg.size(); e++) begin
            frame = 1'b0;
            err   = 1'b0;
            if (rst_edge(e)) begin
                for (int k = 0; k < 4; k++) m_bin[k] = '0;
                m_valid = '0; m_seen = '0; idle = 0; run_ok = 1'b0;
            end else begin
                if (e < 3 || rst_edge(e - 1) || rst_edge(e - 2)) v = '1;
                else v = {slot_seg[e - 3], slot_an[e - 3]};
                acc = run_ok && an_ok(run_val[3:0]) && (e - run_start == SETTLE);
                if (acc) begin
                    idle = 0;
                    sel = 0;
                    for (int k = 0; k < 4; k++) if (!run_val[k]) sel = k;
                    v_digit = seg_val(run_val[10:4]);
                    if (v_digit >= 0) begin
                        m_bin[sel]   = 4'(v_digit);
                        m_valid[sel] = 1'b1;
                        m_seen[sel]  = 1'b1;
                        if (m_seen == 4'hf) begin
                            frame  = 1'b1;
                            m_seen = '0;
                        end
                    end else begin
                        err = 1'b1;
                        m_valid[sel] = 1'b0;
                    end
                end else begin
                    if (idle == TIMEOUT - 1) begin
                        m_valid = '0;
                        m_seen  = '0;
                    end
                    if (idle < TIMEOUT) idle++;
                end
                if (!run_ok || v != run_val) begin
                    run_val   = v;
                    run_start = e;
                    run_ok    = 1'b1;
                end
            end
            snap = {m_bin[3], m_bin[2], m_bin[1], m_bin[0], m_valid, frame, err};
            if (e >= 4 && (snap != prev || frame || err)) exp_q.push_back('{e, snap});
            prev = snap;
        end
    endtask

    task automatic build_stimulus();
        logic [3:0] an_sel [4];
        int         vals [4];
        int         prev_v, kind, len;
        logic [6:0] s;
        logic [3:0] a;
        an_sel[0] = 4'b1110; an_sel[1] = 4'b1101; an_sel[2] = 4'b1011; an_sel[3] = 4'b0111;
        add_seg(7'h7f, 4'hf, 3, 1'b1);
        add_seg(7'h7f, 4'hf, 5, 1'b0);
        // Single steady digit 2 on slot 0.
        add_seg(pat_tab[2], 4'b1110, 20, 1'b0);
        add_seg(7'h7f, 4'hf, 6, 1'b0);
        // Full frame 1, 9, A, F.
        vals[0] = 1; vals[1] = 9; vals[2] = 10; vals[3] = 15;
        for (int i = 0; i < 4; i++) add_seg(pat_tab[vals[i]], an_sel[i], 16, 1'b0);
        // Same frame, each slot preceded by an anode-overlap glitch and stale segments.
        prev_v = 15;
        for (int i = 0; i < 4; i++) begin
            add_seg(pat_tab[vals[i]], 4'b1100, 2, 1'b0);
            add_seg(pat_tab[prev_v], an_sel[i], 2, 1'b0);
            add_seg(pat_tab[vals[i]], an_sel[i], 16, 1'b0);
            prev_v = vals[i];
        end
        // All-off pattern on slot 2 held for a long time.
        add_seg(7'h7f, 4'b1011, 20, 1'b0);
        // Refill a frame, then blank well past the timeout.
        for (int i = 0; i < 4; i++) add_seg(pat_tab[4 + i], an_sel[i], 16, 1'b0);
        add_seg(7'h7f, 4'hf, 60, 1'b0);
        // Frame with a reset pulse in the middle of the digit-3 settle window.
        for (int i = 0; i < 3; i++) add_seg(pat_tab[11 + i], an_sel[i], 16, 1'b0);
        add_seg(pat_tab[8], 4'b0111, 4, 1'b0);
        add_seg(pat_tab[8], 4'b0111, 1, 1'b1);
        add_seg(pat_tab[8], 4'b0111, 20, 1'b0);
        add_seg(7'h7f, 4'hf, 10, 1'b0);
        // Random segments: long legal holds, short glitches, blanks, illegal anodes.
        for (int i = 0; i < 300; i++) begin
            do begin
                kind = $urandom_range(0, 9);
                if ($urandom_range(0, 9) < 8) s = pat_tab[$urandom_range(0, 15)];
                else s = 7'($urandom());
                if (kind < 6) begin
                    a = an_sel[$urandom_range(0, 3)];
                    len = $urandom_range(SETTLE + 3, SETTLE + 12);
                end else if (kind < 8) begin
                    a = an_sel[$urandom_range(0, 3)];
                    len = $urandom_range(1, SETTLE - 1);
                end else if (kind == 8) begin
                    a = 4'hf;
                    len = $urandom_range(1, 10);
                end else begin
                    do a = 4'($urandom()); while (an_ok(a) || a == 4'hf);
                    len = $urandom_range(1, 6);
                end
            end while ({s, a} == {last_seg, last_an});
            add_seg(s, a, len, 1'b0);
        end
        add_seg(7'h7f, 4'hf, 70, 1'b0);
    endtask

    task automatic drive();
        for (int d = 0; d < slot_seg.size(); d++) begin
            @(posedge clk);
            #1;
            seg = slot_seg[d];
            an  = slot_an[d];
            rst = slot_rst[d];
        end
    endtask

    task automatic monitor();
        logic [21:0] snap, prev;
        exp_t        x;
        prev = '0;
        for (int e = 0; e < slot_seg.size(); e++) begin
            @(negedge clk);
            snap = {bin3, bin2, bin1, bin0, digit_valid, frame_done, decode_err};
            if (e == 3) begin
                n_tests++;
                if (snap !== 22'h0) begin
                    n_fail++;
                    $display("FAIL reset_state: got %h, expected 000000", snap);
                end
            end else if (e >= 4 && (snap !== prev || frame_done || decode_err)) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d: got bins=%h valid=%b frame=%b err=%b, expected no change",
                             e, snap[21:6], snap[5:2], snap[1], snap[0]);
                end else begin
                    x = exp_q.pop_front();
                    if (x.cyc != e || x.snap !== snap) begin
                        n_fail++;
                        $display("FAIL event: got cyc=%0d bins=%h valid=%b frame=%b err=%b, expected cyc=%0d bins=%h valid=%b frame=%b err=%b",
                                 e, snap[21:6], snap[5:2], snap[1], snap[0],
                                 x.cyc, x.snap[21:6], x.snap[5:2], x.snap[1], x.snap[0]);
                    end
                end
            end
            prev = snap;
        end
    endtask

    initial begin
        rst = 1'b1;
        seg = 7'h7f;
        an  = 4'hf;
        void'($urandom(32'd20240611));
        pat_tab[0]  = 7'b1000000; pat_tab[1]  = 7'b1111001;
        pat_tab[2]  = 7'b0100100; pat_tab[3]  = 7'b0110000;
        pat_tab[4]  = 7'b0011001; pat_tab[5]  = 7'b0010010;
        pat_tab[6]  = 7'b0000010; pat_tab[7]  = 7'b1111000;
        pat_tab[8]  = 7'b0000000; pat_tab[9]  = 7'b0010000;
        pat_tab[10] = 7'b0001000; pat_tab[11] = 7'b0000011;
        pat_tab[12] = 7'b1000110; pat_tab[13] = 7'b0100001;
        pat_tab[14] = 7'b0000110; pat_tab[15] = 7'b0001110;
        build_stimulus();
        run_model();
        fork
            drive();
            monitor();
        join
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d expected events unobserved, expected 0",
                     exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
